// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM between
// NumPorts requesters with a req/gnt/rvalid handshake. Byte addresses are
// mapped onto SRAM words relative to BaseAddr; accesses outside the SRAM
// window are answered with an error response and never reach the SRAM.
module sram_rr_arbiter #(
  parameter int          NumPorts   = 2,
  parameter int          Width      = 32,
  parameter int          Depth      = 1 << 15,
  parameter logic [31:0] BaseAddr   = 32'h8000_0000,
  localparam int         WidthBytes = Width / 8,
  localparam int         Aw         = $clog2(Depth)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumPorts-1:0]              req_i,
  input  logic [NumPorts-1:0]              we_i,
  input  logic [NumPorts*32-1:0]           addr_i,
  input  logic [NumPorts*Width-1:0]        wdata_i,
  input  logic [NumPorts*WidthBytes-1:0]   be_i,
  output logic [NumPorts-1:0]              gnt_o,
  output logic [NumPorts-1:0]              rvalid_o,
  output logic [NumPorts*Width-1:0]        rdata_o,
  output logic [NumPorts-1:0]              err_o,
  output logic                             sram_req_o,
  output logic                             sram_write_o,
  output logic [Aw-1:0]                    sram_addr_o,
  output logic [Width-1:0]                 sram_wdata_o,
  output logic [Width-1:0]                 sram_wmask_o,
  input  logic [Width-1:0]                 sram_rdata_i
);

  localparam int Pw   = $clog2(NumPorts);
  localparam int OffW = $clog2(WidthBytes);
  // Window bounds in 33 bits so a window ending at 2^32 cannot wrap to a false hit.
  localparam logic [32:0] Base33  = {1'b0, BaseAddr};
  localparam logic [32:0] Limit33 = Base33 + 33'(Depth) * 33'(WidthBytes);

  genvar gi;

  logic [NumPorts-1:0] in_range;
  logic [Aw-1:0]       word_idx [NumPorts];

  // Per-port window check and byte-address to word-index conversion.
  generate
    for (gi = 0; gi < NumPorts; gi++) begin : g_addr
      logic [32:0] addr33;
      logic [32:0] off33;
      assign addr33          = {1'b0, addr_i[gi*32 +: 32]};
      assign off33           = addr33 - Base33;
      assign in_range[gi]    = (addr33 >= Base33) && (addr33 < Limit33);
      assign word_idx[gi]    = Aw'(off33 >> OffW);
    end
  endgenerate

  logic [Pw-1:0] ptr_reg;
  logic [Pw-1:0] win;
  logic          found;

  // Pick the first requester at or after the pointer, wrapping around.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    gnt_o = '0;
    for (int i = 0; i < NumPorts; i++) begin
      idx = int'(ptr_reg) + i;
      if (idx >= NumPorts) idx = idx - NumPorts;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win   = Pw'(idx);
      end
    end
    if (found) gnt_o[win] = 1'b1;
  end

  logic                  win_in_range;
  logic                  win_we;
  logic [Aw-1:0]         win_idx;
  logic [Width-1:0]      win_wdata;
  logic [WidthBytes-1:0] win_be;
  logic [Width-1:0]      win_mask;

  // Steer the winner's request fields onto the SRAM side.
  always_comb begin
    win_in_range = in_range[win];
    win_we       = we_i[win];
    win_idx      = word_idx[win];
    win_wdata    = wdata_i[win*Width +: Width];
    win_be       = be_i[win*WidthBytes +: WidthBytes];
  end

  // Expand byte enables into the per-bit SRAM mask.
  generate
    for (gi = 0; gi < WidthBytes; gi++) begin : g_mask
      assign win_mask[gi*8 +: 8] = {8{win_be[gi]}};
    end
  endgenerate

  // Issue only granted in-window accesses; idle SRAM outputs are held at 0.
  always_comb begin
    sram_req_o   = found && win_in_range;
    sram_write_o = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_wmask_o = '0;
    if (sram_req_o) begin
      sram_write_o = win_we;
      sram_addr_o  = win_idx;
      sram_wdata_o = win_wdata;
      sram_wmask_o = win_mask;
    end
  end

  // Advance the priority pointer past the winner; hold it on idle cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_reg <= '0;
    end else if (found) begin
      ptr_reg <= (win == Pw'(NumPorts - 1)) ? '0 : win + 1'b1;
    end
  end

  logic [NumPorts-1:0] rvalid_reg;
  logic [NumPorts-1:0] err_reg;
  logic [NumPorts-1:0] rd_sel_reg;

  // Record which port gets a response next cycle, and of which kind.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_reg <= '0;
      err_reg    <= '0;
      rd_sel_reg <= '0;
    end else begin
      rvalid_reg <= gnt_o;
      err_reg    <= (found && !win_in_range) ? gnt_o : '0;
      rd_sel_reg <= (found && win_in_range && !win_we) ? gnt_o : '0;
    end
  end

  assign rvalid_o = rvalid_reg;
  assign err_o    = err_reg;

  // SRAM read data only exists in the response cycle, so it is passed through
  // a registered per-port select rather than re-registered.
  generate
    for (gi = 0; gi < NumPorts; gi++) begin : g_rdata
      assign rdata_o[gi*Width +: Width] = rd_sel_reg[gi] ? sram_rdata_i : '0;
    end
  endgenerate

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter with a behavioural single-port SRAM.
module tb_sram_rr_arbiter;

  localparam int NP = 2;
  localparam int W  = 32;
  localparam int D  = 1 << 15;
  localparam int AW = 15;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NP-1:0]   req, we, gnt, rvalid, err;
  logic [NP*32-1:0] addr;
  logic [NP*W-1:0] wdata, rdata;
  logic [NP*4-1:0] be;
  logic            sram_req, sram_write;
  logic [AW-1:0]   sram_addr;
  logic [W-1:0]    sram_wdata, sram_wmask;
  logic [W-1:0]    sram_rdata = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sram_rr_arbiter dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .we_i         (we),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .be_i         (be),
    .gnt_o        (gnt),
    .rvalid_o     (rvalid),
    .rdata_o      (rdata),
    .err_o        (err),
    .sram_req_o   (sram_req),
    .sram_write_o (sram_write),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_wmask_o (sram_wmask),
    .sram_rdata_i (sram_rdata)
  );

  // Behavioural SRAM with a side preload path.
  logic [W-1:0]  mem [0:D-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [W-1:0]  pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (sram_req) begin
      if (sram_write) mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
      else            sram_rdata <= mem[sram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic idle();
    req = '0; we = '0; addr = '0; wdata = '0; be = '0;
  endtask

  task automatic put(input int p, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b);
    req[p] = 1'b1;
    we[p] = w;
    addr[p*32 +: 32] = a;
    wdata[p*W +: W] = d;
    be[p*4 +: 4] = b;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    preload(15'd4, 32'hDEAD_BEEF);
    preload(15'd2, 32'h1122_3344);
    preload(15'd0, 32'hA0A0_A0A0);
    preload(15'd1, 32'hB1B1_B1B1);
    preload(15'h7FFF, 32'h5A5A_1234);

    // Reset state
    #1;
    chk("reset rvalid", 32'(rvalid), 32'h0);
    chk("reset err", 32'(err), 32'h0);
    chk("reset rdata0", rdata[31:0], 32'h0);
    chk("reset rdata1", rdata[63:32], 32'h0);
    chk("reset gnt", 32'(gnt), 32'h0);
    chk("reset sram_req", 32'(sram_req), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Single read by port 0
    @(negedge clk); put(0, 1'b0, 32'h8000_0010, 32'h0, 4'hF);
    #1;
    chk("rd gnt", 32'(gnt), 32'h1);
    chk("rd sram_req", 32'(sram_req), 32'h1);
    chk("rd sram_write", 32'(sram_write), 32'h0);
    chk("rd sram_addr", 32'(sram_addr), 32'h4);
    @(negedge clk); idle();
    #1;
    chk("rd rvalid", 32'(rvalid), 32'h1);
    chk("rd err", 32'(err), 32'h0);
    chk("rd rdata0", rdata[31:0], 32'hDEAD_BEEF);

    // Partial write by port 1, then read back by port 0 back-to-back
    @(negedge clk); put(1, 1'b1, 32'h8000_0008, 32'h00AB_0000, 4'b0100);
    #1;
    chk("wr gnt", 32'(gnt), 32'h2);
    chk("wr sram_req", 32'(sram_req), 32'h1);
    chk("wr sram_write", 32'(sram_write), 32'h1);
    chk("wr sram_addr", 32'(sram_addr), 32'h2);
    chk("wr sram_wmask", sram_wmask, 32'h00FF_0000);
    chk("wr sram_wdata", sram_wdata, 32'h00AB_0000);
    @(negedge clk); idle(); put(0, 1'b0, 32'h8000_0008, 32'h0, 4'hF);
    #1;
    chk("wr rvalid", 32'(rvalid), 32'h2);
    chk("wr err", 32'(err), 32'h0);
    chk("wr rdata1", rdata[63:32], 32'h0);
    chk("rb gnt", 32'(gnt), 32'h1);
    chk("rb sram_addr", 32'(sram_addr), 32'h2);
    @(negedge clk); idle();
    #1;
    chk("rb rvalid", 32'(rvalid), 32'h1);
    chk("rb rdata0", rdata[31:0], 32'h11AB_3344);

    // Out of range below and above the window
    @(negedge clk); put(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'hF);
    #1;
    chk("oor lo gnt", 32'(gnt), 32'h1);
    chk("oor lo sram_req", 32'(sram_req), 32'h0);
    @(negedge clk); put(0, 1'b0, 32'h8002_0000, 32'h0, 4'hF);
    #1;
    chk("oor lo rvalid", 32'(rvalid), 32'h1);
    chk("oor lo err", 32'(err), 32'h1);
    chk("oor lo rdata0", rdata[31:0], 32'h0);
    chk("oor hi sram_req", 32'(sram_req), 32'h0);
    @(negedge clk); idle();
    #1;
    chk("oor hi rvalid", 32'(rvalid), 32'h1);
    chk("oor hi err", 32'(err), 32'h1);
    chk("oor hi rdata0", rdata[31:0], 32'h0);

    // Last word of the window
    @(negedge clk); put(0, 1'b0, 32'h8001_FFFC, 32'h0, 4'hF);
    #1;
    chk("edge sram_req", 32'(sram_req), 32'h1);
    chk("edge sram_addr", 32'(sram_addr), 32'h7FFF);
    @(negedge clk); idle();
    #1;
    chk("edge rvalid", 32'(rvalid), 32'h1);
    chk("edge err", 32'(err), 32'h0);
    chk("edge rdata0", rdata[31:0], 32'h5A5A_1234);

    // Write with no byte enables still issues, with an empty mask
    @(negedge clk); put(1, 1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 4'h0);
    #1;
    chk("be0 sram_req", 32'(sram_req), 32'h1);
    chk("be0 sram_write", 32'(sram_write), 32'h1);
    chk("be0 sram_wmask", sram_wmask, 32'h0);
    @(negedge clk); idle();
    #1;
    chk("be0 rvalid", 32'(rvalid), 32'h2);
    chk("be0 err", 32'(err), 32'h0);

    // Reset while a grant's response is still in flight
    @(negedge clk); put(0, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
    #1;
    chk("rst g1 gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    #1;
    chk("rst r1 rvalid", 32'(rvalid), 32'h1);
    chk("rst g2 gnt", 32'(gnt), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst drop rvalid", 32'(rvalid), 32'h0);
    idle();
    @(negedge clk);
    #1;
    chk("rst hold rvalid", 32'(rvalid), 32'h0);
    chk("rst hold err", 32'(err), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("rst rel rvalid", 32'(rvalid), 32'h0);

    // Contention: alternate grants starting at port 0, responses in order
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      put(0, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
      put(1, 1'b0, 32'h8000_0004, 32'h0, 4'hF);
      #1;
      chk($sformatf("cont gnt %0d", k), 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k > 0) begin
        chk($sformatf("cont rvalid %0d", k - 1), 32'(rvalid), ((k - 1) % 2 == 0) ? 32'h1 : 32'h2);
        chk($sformatf("cont rdata %0d", k - 1), rdata[((k - 1) % 2)*32 +: 32],
            ((k - 1) % 2 == 0) ? 32'hA0A0_A0A0 : 32'hB1B1_B1B1);
      end
    end
    @(negedge clk); idle();
    #1;
    chk("cont rvalid 5", 32'(rvalid), 32'h2);
    chk("cont rdata 5", rdata[63:32], 32'hB1B1_B1B1);
    @(negedge clk);
    #1;
    chk("cont tail rvalid", 32'(rvalid), 32'h0);
    chk("cont tail gnt", 32'(gnt), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
